// File: rtl/checker_pkg.sv
// checker_pkg: shared state enum, table entry layout and clog2 helper for store_checker
package checker_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, PASS, FAIL, TMO} state_t;
  localparam int ENTRY_ADDR_W = 64;
  localparam int ENTRY_DATA_W = 64;
  localparam int ENTRY_MASK_W = ENTRY_DATA_W / 8;
  // Entries are stored at the widest supported port width; narrower ports zero-extend.
  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
    logic [ENTRY_MASK_W-1:0] mask;
  } entry_t;
  function automatic int clog2(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/masked_cmp.sv
// masked_cmp: byte-lane equality compare where only lanes with mask=1 take part
module masked_cmp #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [DATA_W/8-1:0] mask,
  output logic                eq
);
  logic [DATA_W/8-1:0] lane_ok;
  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_lane
    assign lane_ok[i] = !mask[i] || a[8*i +: 8] == b[8*i +: 8];
  end
  assign eq = &lane_ok;
endmodule

// File: rtl/store_checker.sv
// store_checker: ordered, maskable, time-bounded monitor of a data-memory write port (ADDR_W, DATA_W <= 64)
module store_checker
  import checker_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int N_CHECKS = 4,
  parameter int TMO_W    = 16,
  parameter int STRICT   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MemWrite,
  input  logic [ADDR_W-1:0]            DataAdr,
  input  logic [DATA_W-1:0]            WriteData,
  input  logic                         cfg_we,
  input  logic [clog2(N_CHECKS)-1:0]   cfg_idx,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic [DATA_W-1:0]            cfg_data,
  input  logic [DATA_W/8-1:0]          cfg_mask,
  input  logic [clog2(N_CHECKS):0]     num_checks,
  input  logic [TMO_W-1:0]             tmo_limit,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [clog2(N_CHECKS)-1:0]   fail_idx,
  output logic [ADDR_W-1:0]            fail_addr,
  output logic [DATA_W-1:0]            fail_data,
  output logic                         timed_out
);
  localparam int IW = clog2(N_CHECKS);
  state_t                  state;
  logic [IW-1:0]           idx;
  logic [TMO_W-1:0]        cnt;
  entry_t                  tbl [N_CHECKS];
  entry_t                  cur;
  logic [ENTRY_ADDR_W-1:0] adr_x;
  logic [N_CHECKS-1:0]     ahead;
  logic                    data_ok, hit, last, ooo, tmo_hit, nc_ok;
  masked_cmp #(.DATA_W(ENTRY_DATA_W)) u_cmp (
    .a   (ENTRY_DATA_W'(WriteData)),
    .b   (cur.data),
    .mask(cur.mask),
    .eq  (data_ok)
  );
  // A store to a later still-pending entry means the program wrote out of order.
  for (genvar j = 0; j < N_CHECKS; j++) begin : g_ahead
    assign ahead[j] = tbl[j].addr == adr_x && IW'(j) > idx && (IW+1)'(j) < num_checks;
  end
  always_comb begin
    adr_x   = ENTRY_ADDR_W'(DataAdr);
    cur     = tbl[idx];
    hit     = MemWrite && adr_x == cur.addr;
    last    = {1'b0, idx} == num_checks - 1'b1;
    ooo     = STRICT != 0 && MemWrite && !hit && |ahead;
    tmo_hit = tmo_limit != '0 && cnt == tmo_limit - 1'b1;
    nc_ok   = num_checks != '0 && num_checks <= (IW+1)'(N_CHECKS);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
      fail_idx  <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we && 32'(cfg_idx) < N_CHECKS)
            tbl[cfg_idx] <= '{addr: ENTRY_ADDR_W'(cfg_addr), data: ENTRY_DATA_W'(cfg_data), mask: ENTRY_MASK_W'(cfg_mask)};
          if (start) begin
            idx   <= '0;
            cnt   <= '0;
            state <= nc_ok ? ARMED : FAIL;
            busy  <= nc_ok;
            done  <= !nc_ok;
          end
        end
        ARMED: begin
          cnt <= cnt + 1'b1;
          // Store-driven endings take priority over the timeout in the same cycle.
          if (hit && data_ok && last) begin
            state    <= PASS;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b1;
            fail_idx <= idx;
          end else if ((hit && !data_ok) || ooo) begin
            state     <= FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_idx  <= idx;
            fail_addr <= DataAdr;
            fail_data <= WriteData;
          end else if (tmo_hit) begin
            state     <= TMO;
            busy      <= 1'b0;
            done      <= 1'b1;
            timed_out <= 1'b1;
            fail_idx  <= idx;
          end else if (hit) begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker: vector table plus scoreboard for store_checker, lenient and strict instances side by side
module tb_store_checker;
  typedef struct packed {
    logic        pass;
    logic        to;
    logic [1:0]  idx;
    logic [31:0] fa;
    logic [31:0] fd;
  } res_t;
  typedef struct {
    int               tsel;
    int               nc;
    int               tmo;
    int               nst;
    logic [0:4][31:0] sa;
    logic [0:4][31:0] sd;
    res_t             e0;
    res_t             e1;
  } vec_t;
  localparam logic [31:0] Z = 32'd0;
  logic        clk = 1'b0;
  logic        reset = 1'b0, MemWrite = 1'b0, cfg_we = 1'b0, start = 1'b0;
  logic [31:0] DataAdr = '0, WriteData = '0, cfg_addr = '0, cfg_data = '0;
  logic [1:0]  cfg_idx = '0;
  logic [3:0]  cfg_mask = '0;
  logic [2:0]  num_checks = '0;
  logic [15:0] tmo_limit = '0;
  logic        busy0, done0, pass0, to0, busy1, done1, pass1, to1;
  logic [1:0]  fidx0, fidx1;
  logic [31:0] fa0, fd0, fa1, fd1;
  int          n_run = 0, n_fail = 0;
  res_t        q[$];
  vec_t        vt[8];
  store_checker #(.STRICT(0)) u0 (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mask(cfg_mask),
    .num_checks(num_checks), .tmo_limit(tmo_limit), .start(start),
    .busy(busy0), .done(done0), .pass(pass0), .fail_idx(fidx0), .fail_addr(fa0), .fail_data(fd0), .timed_out(to0)
  );
  store_checker #(.STRICT(1)) u1 (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mask(cfg_mask),
    .num_checks(num_checks), .tmo_limit(tmo_limit), .start(start),
    .busy(busy1), .done(done1), .pass(pass1), .fail_idx(fidx1), .fail_addr(fa1), .fail_data(fd1), .timed_out(to1)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
  function automatic res_t r(int p, int t, int i, int a, int d);
    r = '{p != 0, t != 0, 2'(i), 32'(a), 32'(d)};
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cmp_res(string nm, res_t g, res_t e);
    chk({nm, ".pass"}, 64'(g.pass), 64'(e.pass));
    chk({nm, ".timed_out"}, 64'(g.to), 64'(e.to));
    chk({nm, ".fail_idx"}, 64'(g.idx), 64'(e.idx));
    chk({nm, ".fail_addr"}, 64'(g.fa), 64'(e.fa));
    chk({nm, ".fail_data"}, 64'(g.fd), 64'(e.fd));
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1; MemWrite = 1'b0; cfg_we = 1'b0; start = 1'b0;
    tick;
    reset = 1'b0;
  endtask
  task automatic wr(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    cfg_we = 1'b1; cfg_idx = i; cfg_addr = a; cfg_data = d; cfg_mask = m;
    tick;
    cfg_we = 1'b0;
  endtask
  task automatic prog(input int tsel);
    if (tsel == 0) wr(2'd0, 32'd200, 32'h3fe00000, 4'hF);
    else begin
      wr(2'd0, 32'd100, 32'h000000AA, 4'h1);
      wr(2'd1, 32'd104, 32'h12345678, 4'hF);
      wr(2'd2, 32'd200, 32'h3f800000, 4'hC);
    end
  endtask
  task automatic arm(input int nc, input int tmo);
    num_checks = 3'(nc); tmo_limit = 16'(tmo); start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    tick;
    MemWrite = 1'b0;
  endtask
  initial begin
    vt[0] = '{0, 1, 0, 1, '{32'd200, Z, Z, Z, Z}, '{32'h3fe00000, Z, Z, Z, Z}, r(1, 0, 0, 0, 0), r(1, 0, 0, 0, 0)};
    vt[1] = '{0, 1, 0, 1, '{32'd200, Z, Z, Z, Z}, '{32'h3ff00000, Z, Z, Z, Z},
              r(0, 0, 0, 200, 32'h3ff00000), r(0, 0, 0, 200, 32'h3ff00000)};
    vt[2] = '{1, 3, 0, 5, '{32'd100, 32'd300, 32'd104, 32'd300, 32'd200},
              '{32'h123456AA, Z, 32'h12345678, 32'd5, 32'h3f80FFFF}, r(1, 0, 2, 0, 0), r(1, 0, 2, 0, 0)};
    vt[3] = '{1, 3, 0, 4, '{32'd104, 32'd100, 32'd104, 32'd200, Z},
              '{32'h12345678, 32'h000000AA, 32'h12345678, 32'h3f800000, Z},
              r(1, 0, 2, 0, 0), r(0, 0, 0, 104, 32'h12345678)};
    vt[4] = '{1, 3, 0, 2, '{32'd100, 32'd104, Z, Z, Z}, '{32'h000000AA, 32'h12345679, Z, Z, Z},
              r(0, 0, 1, 104, 32'h12345679), r(0, 0, 1, 104, 32'h12345679)};
    vt[5] = '{1, 3, 0, 4, '{32'd100, 32'd200, 32'd104, 32'd200, Z},
              '{32'h000000AA, 32'h3f800000, 32'h12345678, 32'h3f800000, Z},
              r(1, 0, 2, 0, 0), r(0, 0, 1, 200, 32'h3f800000)};
    vt[6] = '{1, 2, 0, 3, '{32'd100, 32'd200, 32'd104, Z, Z},
              '{32'h000000AA, 32'h3f800000, 32'h12345678, Z, Z}, r(1, 0, 1, 0, 0), r(1, 0, 1, 0, 0)};
    vt[7] = '{1, 3, 5, 1, '{32'd100, Z, Z, Z, Z}, '{32'h000000AA, Z, Z, Z, Z}, r(0, 1, 1, 0, 0), r(0, 1, 1, 0, 0)};
    do_reset;
    chk("reset.flags", 64'({busy0, done0, pass0, to0, busy1, done1, pass1, to1}), 64'd0);
    chk("reset.capture", {fa0 | fa1, fd0 | fd1}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      int   k;
      res_t e0, e1;
      do_reset;
      prog(vt[i].tsel);
      q.push_back(vt[i].e0);
      q.push_back(vt[i].e1);
      arm(vt[i].nc, vt[i].tmo);
      for (int s = 0; s < vt[i].nst; s++) st(vt[i].sa[s], vt[i].sd[s]);
      k = 0;
      while (!(done0 && done1) && k < 20) begin
        tick;
        k++;
      end
      chk($sformatf("v%0d.done", i), 64'({done0, done1, busy0, busy1}), 64'b1100);
      e0 = q.pop_front();
      e1 = q.pop_front();
      cmp_res($sformatf("v%0d.u0", i), '{pass0, to0, fidx0, fa0, fd0}, e0);
      cmp_res($sformatf("v%0d.u1", i), '{pass1, to1, fidx1, fa1, fd1}, e1);
    end
    do_reset;
    chk("reset_after_tmo", 64'({busy0, done0, pass0, to0, fidx0, fa0, fd0}), 64'd0);
    // Timeout lands exactly on the 10th edge after start.
    do_reset; prog(0); arm(1, 10);
    repeat (9) tick;
    chk("tmo.early", 64'({to0, done0, busy0}), 64'b001);
    tick;
    chk("tmo.edge", 64'({to0, done0, pass0, busy0, to1}), 64'b11001);
    chk("tmo.capture", {fa0, fd0}, 64'd0);
    // Matching store on the same edge as the timeout.
    do_reset; prog(0); arm(1, 3);
    tick; tick;
    chk("sim.pre", 64'({done0, done1}), 64'd0);
    st(32'd200, 32'h3fe00000);
    chk("sim.pass", 64'({pass0, to0, done0, pass1, to1}), 64'b10110);
    // Mid-run reset then restart.
    do_reset; prog(1); arm(3, 0);
    st(32'd100, 32'h000000AA);
    chk("mid.busy", 64'({busy0, done0}), 64'b10);
    reset = 1'b1; tick; reset = 1'b0;
    chk("mid.reset", 64'({busy0, done0, pass0, to0, fidx0, busy1, done1}), 64'd0);
    arm(3, 0);
    chk("mid.restart", 64'({busy0, done0, busy1}), 64'b101);
    // Invalid num_checks fails immediately; terminal state ignores start.
    do_reset; arm(0, 0);
    chk("nc0.flags", 64'({done0, pass0, busy0, fidx0, done1}), 64'b100001);
    chk("nc0.capture", {fa0, fd0}, 64'd0);
    arm(1, 0);
    chk("nc0.sticky", 64'({done0, busy0, pass0}), 64'b100);
    do_reset; arm(5, 0);
    chk("nc5.flags", 64'({done0, pass0, busy0}), 64'b100);
    // Entry write in the start cycle is the one the run checks.
    do_reset; prog(0);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 32'd400; cfg_data = 32'd1; cfg_mask = 4'hF;
    num_checks = 3'd1; tmo_limit = 16'd0; start = 1'b1;
    tick;
    cfg_we = 1'b0; start = 1'b0;
    st(32'd200, 32'h3fe00000);
    chk("cfgstart.old", 64'({done0, done1, busy0}), 64'b001);
    st(32'd400, 32'd1);
    chk("cfgstart.new", 64'({pass0, pass1, done0}), 64'b111);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/store_checker.md
# store_checker

Synthesizable self-check monitor for the single-cycle processor's data-memory write port. It holds a programmable, ordered list of expected stores (address, data, byte-lane mask) and watches `MemWrite`/`DataAdr`/`WriteData` from `top`. It reports pass, fail or timeout, and captures the offending write. It sits beside `top`, in the testbench and on the FPGA wrapper, and replaces ad-hoc single-address checks with a multi-entry, maskable, time-bounded check.

## Interface
- `DATA_W`, default 32: width of `WriteData` and of the expected data.
- `ADDR_W`, default 32: width of `DataAdr` and of the expected address.
- `N_CHECKS`, default 4: depth of the expected-store table. Must be at least 1.
- `TMO_W`, default 16: width of the timeout counter and of `tmo_limit`.
- `STRICT`, default 0: when 1, a write to a watched address that arrives out of order is a failure.

- `clk`, input, 1: the only clock. All state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `MemWrite`, input, 1: store strobe from `top`.
- `DataAdr`, input, ADDR_W: store address.
- `WriteData`, input, DATA_W: store data.
- `cfg_we`, input, 1: write one table entry. Accepted only in IDLE.
- `cfg_idx`, input, clog2(N_CHECKS): table entry to write.
- `cfg_addr`, input, ADDR_W: expected address.
- `cfg_data`, input, DATA_W: expected data.
- `cfg_mask`, input, DATA_W/8: byte lanes to compare; 1 means compare that lane.
- `num_checks`, input, clog2(N_CHECKS)+1: number of active entries. Valid range 1..N_CHECKS.
- `tmo_limit`, input, TMO_W: cycle budget. 0 disables the timeout.
- `start`, input, 1: arm the checker. Accepted only in IDLE.
- `busy`, output, 1: checker is ARMED.
- `done`, output, 1: checker is in PASS, FAIL or TMO.
- `pass`, output, 1: checker is in PASS.
- `fail_idx`, output, clog2(N_CHECKS): entry being checked when the run ended.
- `fail_addr`, output, ADDR_W: captured address of the failing store.
- `fail_data`, output, DATA_W: captured data of the failing store.
- `timed_out`, output, 1: checker is in TMO.

## Operation
- States: IDLE, ARMED, PASS, FAIL, TMO.
- **Reset:**
  - State goes to IDLE.
  - All outputs go to 0.
  - The index and timeout counter go to 0.
  - Table contents are undefined after reset.
- **IDLE:**
  - `cfg_we` writes entry `cfg_idx`. `cfg_idx` >= N_CHECKS is ignored.
  - `start` moves to ARMED. Index and counter clear to 0.
  - `start` with `num_checks` of 0 or > N_CHECKS goes straight to FAIL, with `fail_idx`=0 and the capture registers at 0.
- **ARMED, on a cycle with `MemWrite`=1:**
  - Address hit means `DataAdr` == addr[idx].
  - On a hit, compare each byte lane of `WriteData` with data[idx] where mask[idx] is 1.
  - Hit and data match: the index advances. If the index was `num_checks`-1, go to PASS.
  - Hit and data mismatch: go to FAIL. Capture `DataAdr` and `WriteData`. `fail_idx` = idx.
  - No hit, `STRICT`=1, and `DataAdr` equals addr[j] for some j with idx < j < `num_checks`: go to FAIL with the same captures and `fail_idx` = idx.
  - Any other miss is ignored.
- **ARMED, timeout:** the counter increments every cycle. If `tmo_limit` != 0 and the counter reaches `tmo_limit`-1 with no terminal event in that cycle, go to TMO. Captures stay 0 and `fail_idx` = idx.
- **Simultaneous events:** a store-driven transition (PASS or FAIL) in the same cycle as the timeout wins over TMO.
- **Terminal states:** PASS, FAIL and TMO are sticky. Only `reset` leaves them.
  - `start` and `cfg_we` are ignored in these states and in ARMED.
  - Capture registers are frozen.
- `cfg_we` and `start` in the same IDLE cycle: the entry write takes effect, and the run uses the new entry.

## Timing
- Registered outputs. The state is visible one cycle after the deciding edge: the store sampled at edge N makes `done`/`pass` high after edge N, readable in cycle N+1.
- The checker samples at the same rising edge that commits the store in memory, so it needs no extra pipeline stage.
- Timeout: with `tmo_limit`=L, TMO is entered on the L-th rising edge after the edge that accepted `start`.
- Mid-run `reset` aborts the run. All outputs return to 0 on the next edge.
- Throughput: one store per cycle. Back-to-back matching stores advance the index on consecutive cycles.

## Structure
- Shared package `checker_pkg`:
  - state enum: IDLE, ARMED, PASS, FAIL, TMO.
  - the `clog2` helper.
  - the entry struct {addr, data, mask}.
- Sub-module `masked_cmp`: a combinational byte-lane compare, parametrised on DATA_W.
- Table: flop array of N_CHECKS entries. No RAM inference needed.
- The STRICT look-ahead is a generate loop of N_CHECKS address comparators, qualified by idx < j < `num_checks`.

## Test plan
- **Single entry.** Program entry 0 as {200, 32'h3fe00000, 4'hF}, `num_checks`=1, `tmo_limit`=0, then start. The program stores 32'h3fe00000 at 200 → `pass`=1, `done`=1 the next cycle.
- **Data mismatch.** Same setup, but 32'h3ff00000 is stored at 200 → FAIL, `fail_idx`=0, `fail_addr`=200, `fail_data`=32'h3ff00000.
- **Masked, ordered sequence.** Three entries: {100, 32'h000000AA, 4'h1}, {104, 32'h12345678, 4'hF}, {200, 32'h3f800000, 4'hC}. Stores in order, with an unrelated store to 300 between them, and the third store is 32'h3f80FFFF → PASS.
- **STRICT ordering.** `STRICT`=1, the entries from the previous scenario, first store to 104 → FAIL, `fail_idx`=0, `fail_addr`=104. Repeat with `STRICT`=0 → the out-of-order store is ignored.
- **Timeout.** `tmo_limit`=10, no stores → `timed_out`=1 after the 10th edge following `start`. In a second run, the matching store and the timeout land in the same cycle → PASS.
- **Reset and invalid start.** `reset` mid-run → all outputs 0 and a new `start` is accepted. `start` with `num_checks`=0 → immediate FAIL.
